// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame path.
package uart_tx_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;
   localparam logic        TX_IDLE_LVL        = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; loaded and stepped by the frame FSM.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  ser_bit,
   output logic                  ser_done_c
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]      bit_cnt;

   // Counter saturates on the last bit so it never wraps inside a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shift_q <= load_data;
         bit_cnt <= '0;
      end else if (shift) begin
         shift_q <= shift_q >> 1;
         if (bit_cnt != LAST_CNT) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

   assign ser_bit    = shift_q[0];
   assign ser_done_c = (bit_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame_fsm.sv
// UART frame controller: start, LSB-first data, optional parity, stop on tx_out.
// Define UART_TX_STOP2_EN for two stop bits (frame_done on the second one).
module uart_tx_frame_fsm
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  par_en,
   input  logic                  par_bit,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  frame_done
);

   tx_state_e state;
   tx_state_e state_nxt;
   logic      par_en_q;
   logic      load_c;
   logic      shift_c;
   logic      ser_bit;
   logic      ser_done_c;
   logic      last_stop_c;
   logic      tx_nxt;
   logic      busy_nxt;
   logic      done_nxt;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load       (load_c),
      .shift      (shift_c),
      .load_data  (p_data),
      .ser_bit    (ser_bit),
      .ser_done_c (ser_done_c)
   );

`ifdef UART_TX_STOP2_EN
   logic stop_cnt;

   // Marks the second of two stop cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stop_cnt <= 1'b0;
      end else if (state == STOP) begin
         stop_cnt <= ~stop_cnt;
      end else begin
         stop_cnt <= 1'b0;
      end
   end

   assign last_stop_c = stop_cnt;
`else
   assign last_stop_c = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_en_q <= 1'b0;
      end else if (load_c) begin
         par_en_q <= par_en;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      shift_c   = 1'b0;
      case (state)
         IDLE: begin
            if (data_valid) begin
               state_nxt = START;
               load_c    = 1'b1;
            end
         end
         START:  state_nxt = DATA;
         DATA: begin
            shift_c = 1'b1;
            if (ser_done_c) begin
               state_nxt = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: state_nxt = STOP;
         STOP: begin
            if (last_stop_c) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line level for the current state; registered below, so it lags state by one cycle.
   always_comb begin
      tx_nxt   = TX_IDLE_LVL;
      busy_nxt = 1'b1;
      done_nxt = 1'b0;
      case (state)
         IDLE:    busy_nxt = 1'b0;
         START:   tx_nxt   = 1'b0;
         DATA:    tx_nxt   = ser_bit;
         PARITY:  tx_nxt   = par_bit;
         STOP:    done_nxt = last_stop_c;
         default: busy_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_out     <= TX_IDLE_LVL;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         tx_out     <= tx_nxt;
         busy       <= busy_nxt;
         frame_done <= done_nxt;
      end
   end

endmodule
